// File: rtl/hv_bundle_stream.sv
// hv_bundle_stream: multi-core saturating per-bit majority bundler with a
// snapshot that is streamed out as OUT_W-bit beats over valid/ready.
module hv_bundle_stream #(
  parameter int DIM        = 1023,
  parameter int CORENUM    = 16,
  parameter int CNT_W      = 30,
  parameter int OUT_W      = 1024,
  parameter int TIE_MODE   = 0,
  parameter int AUTO_CLEAR = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CORENUM*(DIM+1)-1:0]   core_result,
  input  logic [CORENUM-1:0]           store,
  input  logic                         finish,
  input  logic                         clear,
  output logic [OUT_W-1:0]             stream_d,
  output logic                         stream_v,
  input  logic                         stream_ready,
  output logic                         stream_last,
  output logic                         busy,
  output logic                         drop,
  output logic                         sat
);
  localparam int W     = DIM + 1;
  localparam int NBEAT = W / OUT_W;
  localparam int BW    = NBEAT > 1 ? $clog2(NBEAT) : 1;
  localparam int DW    = $clog2(CORENUM + 1) + 1;
  localparam int SW    = (CNT_W > DW ? CNT_W : DW) + 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-CNT_W+1){1'b0}}, {(CNT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-CNT_W+1){1'b1}}, {(CNT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SNAP, SEND} state_t;

  state_t                         state_q, state_d;
  logic signed [CNT_W-1:0]        cnt_q [W];
  logic signed [CNT_W-1:0]        cnt_d [W];
  logic [NBEAT-1:0][OUT_W-1:0]    snap_q, snap_d;
  logic [BW-1:0]                  beat_q, beat_d;
  logic                           drop_q, drop_d, sat_q, sat_d;
  logic [W-1:0]                   sign_v;
  logic                           clamp;
  logic signed [SW-1:0]           dl, base, sum;

  // Counter datapath: delta is built in SW bits so neither the delta nor cnt+delta can wrap.
  always_comb begin
    clamp = 1'b0;
    dl    = '0;
    base  = '0;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      dl = '0;
      for (int c = 0; c < CORENUM; c++)
        if (store[c]) dl = core_result[c*W+i] ? dl + SW'(1) : dl - SW'(1);
      base = (state_q == SNAP && AUTO_CLEAR != 0) ? '0 : {{(SW-CNT_W){cnt_q[i][CNT_W-1]}}, cnt_q[i]};
      sum  = base + dl;
      cnt_d[i] = clear ? '0 : sum > MAXV ? MAXV[CNT_W-1:0] : sum < MINV ? MINV[CNT_W-1:0] : sum[CNT_W-1:0];
      clamp = clamp | sum > MAXV | sum < MINV;
      sign_v[i] = cnt_q[i][CNT_W-1] ? 1'b0 : (|cnt_q[i]) ? 1'b1 : (TIE_MODE != 0);
    end
    sat_d  = clear ? 1'b0 : sat_q | clamp;
    drop_d = clear ? 1'b0 : drop_q | (finish && state_q != IDLE);
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: state_d = finish ? SNAP : IDLE;
      SNAP: begin
        snap_d  = sign_v;
        beat_d  = '0;
        state_d = SEND;
      end
      SEND: if (stream_ready) begin
        beat_d  = beat_q + 1'b1;
        state_d = stream_last ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stream_v    = state_q == SEND;
  assign stream_last = stream_v && beat_q == BW'(NBEAT - 1);
  assign stream_d    = stream_v ? snap_q[beat_q] : '0;
  assign busy        = state_q != IDLE;
  assign drop        = drop_q;
  assign sat         = sat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      beat_q  <= '0;
      drop_q  <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < W; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      beat_q  <= beat_d;
      drop_q  <= drop_d;
      sat_q   <= sat_d;
      for (int i = 0; i < W; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_hv_bundle_stream.sv
// tb_hv_bundle_stream: directed scoreboard bench; two instances differ only in TIE_MODE.
module tb_hv_bundle_stream;
  localparam int DIM = 7, CN = 3, CW = 4, OW = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic [CN*8-1:0] cr = '0;
  logic [CN-1:0] store = '0;
  logic          finish = 1'b0, clear = 1'b0, ready = 1'b1;
  logic [OW-1:0] d0, d1;
  logic          v0, v1, l0, l1, b0, b1, dr0, dr1, s0, s1;
  logic [4:0]    q0[$], q1[$];
  int            ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  hv_bundle_stream #(.DIM(DIM), .CORENUM(CN), .CNT_W(CW), .OUT_W(OW), .TIE_MODE(0), .AUTO_CLEAR(1)) dut0 (
    .clk(clk), .rst(rst), .core_result(cr), .store(store), .finish(finish), .clear(clear),
    .stream_d(d0), .stream_v(v0), .stream_ready(ready), .stream_last(l0), .busy(b0), .drop(dr0), .sat(s0));

  hv_bundle_stream #(.DIM(DIM), .CORENUM(CN), .CNT_W(CW), .OUT_W(OW), .TIE_MODE(1), .AUTO_CLEAR(1)) dut1 (
    .clk(clk), .rst(rst), .core_result(cr), .store(store), .finish(finish), .clear(clear),
    .stream_d(d1), .stream_v(v1), .stream_ready(ready), .stream_last(l1), .busy(b1), .drop(dr1), .sat(s1));

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected beats per instance, low nibble first, {last, data}.
  task automatic push(input logic [7:0] a, input logic [7:0] b);
    q0.push_back({1'b0, a[3:0]});
    q0.push_back({1'b1, a[7:4]});
    q1.push_back({1'b0, b[3:0]});
    q1.push_back({1'b1, b[7:4]});
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && ready && v0) begin
        if (q0.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL dut0 unexpected beat: got %0h, expected none", {l0, d0});
        end else check("dut0 beat", {27'd0, l0, d0}, {27'd0, q0.pop_front()});
      end
      if (rst && ready && v1) begin
        if (q1.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL dut1 unexpected beat: got %0h, expected none", {l1, d1});
        end else check("dut1 beat", {27'd0, l1, d1}, {27'd0, q1.pop_front()});
      end
    end
  endtask

  task automatic pattern();
    cr = {8'hAA, 8'hCC, 8'hF0};
    store = 3'b111;
    step();
    store = '0;
    cr = '0;
  endtask

  task automatic fin();
    finish = 1'b1;
    step();
    finish = 1'b0;
  endtask

  initial begin
    fork monitor(); join_none
    step(); step();
    check("reset stream_v", v0, 0);
    check("reset busy", b0, 0);
    check("reset stream_d", d0, 0);
    check("reset stream_last", l0, 0);
    check("reset drop", dr0, 0);
    check("reset sat", s0, 0);
    rst = 1'b1;
    step();
    // majority, latency, back-to-back finish after last handshake
    pattern();
    push(8'hE8, 8'hE8);
    fin();
    check("t1 busy T+1", b0, 1);
    check("t1 stream_v T+1", v0, 0);
    step();
    check("t1 beat0 data", d0, 4'h8);
    check("t1 beat0 last", l0, 0);
    step();
    check("t1 beat1 data", d0, 4'hE);
    check("t1 beat1 last", l0, 1);
    step();
    check("t1 busy T+4", b0, 0);
    push(8'h00, 8'hFF);
    fin();
    check("t1 refinish accepted", b0, 1);
    step(); step(); step();
    check("t1 busy end", b0, 0);
    check("t1 drop", dr0, 0);
    // tie
    cr[7:0] = 8'hFF; store = 3'b001; step();
    cr[7:0] = 8'h00; step();
    store = '0;
    push(8'h00, 8'hFF);
    fin(); step(); step(); step();
    // backpressure
    ready = 1'b0;
    pattern();
    push(8'hE8, 8'hE8);
    fin();
    step();
    for (int k = 0; k < 5; k++) begin
      check("t3 stall data", d0, 4'h8);
      check("t3 stall valid", v0, 1);
      check("t3 stall last", l0, 0);
      step();
    end
    ready = 1'b1;
    step();
    check("t3 beat after ready", d0, 4'hE);
    step();
    check("t3 busy end", b0, 0);
    // saturation
    cr[7:0] = 8'hFF; store = 3'b001;
    repeat (7) step();
    check("t4 sat before clamp", s0, 0);
    repeat (3) step();
    check("t4 sat dut0", s0, 1);
    check("t4 sat dut1", s1, 1);
    cr[7:0] = 8'h00;
    repeat (7) step();
    store = '0;
    push(8'h00, 8'hFF);
    fin(); step(); step(); step();
    check("t4 sat held", s0, 1);
    // overlap
    pattern();
    push(8'hE8, 8'hE8);
    fin();
    cr[7:0] = 8'h0F; store = 3'b001;
    step();
    store = '0; cr = '0;
    check("t5 drop before", dr0, 0);
    fin();
    check("t5 drop set", dr0, 1);
    check("t5 stream data", d0, 4'hE);
    check("t5 stream last", l0, 1);
    step();
    check("t5 idle", b0, 0);
    push(8'h0F, 8'h0F);
    fin(); step(); step(); step();
    check("t5 drop sticky", dr0, 1);
    clear = 1'b1; step(); clear = 1'b0;
    check("t5 clear drop", dr0, 0);
    check("t5 clear sat", s0, 0);
    // finish with clear in the same idle cycle
    pattern();
    push(8'h00, 8'hFF);
    finish = 1'b1; clear = 1'b1; step(); finish = 1'b0; clear = 1'b0;
    step(); step(); step();
    // async reset mid-stream
    pattern();
    push(8'hE8, 8'hE8);
    fin();
    cr[7:0] = 8'h0F; store = 3'b001;
    step();
    store = '0; cr = '0;
    check("t6 streaming", v0, 1);
    #2 rst = 1'b0;
    #1;
    check("t6 rst stream_v", v0, 0);
    check("t6 rst busy", b0, 0);
    check("t6 rst stream_last", l0, 0);
    check("t6 rst stream_d", d0, 0);
    q0.delete();
    q1.delete();
    step(); step();
    rst = 1'b1;
    step();
    push(8'h00, 8'hFF);
    fin(); step(); step(); step();
    check("queue0 drained", q0.size(), 0);
    check("queue1 drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/hv_bundle_stream.md
# hv_bundle_stream

Parametrised bundling accumulator and output serializer for the HPU datapath. It takes DIM+1-bit hypervector results from CORENUM compute cores and keeps one saturating signed majority counter per bit position. On `finish` it snapshots the per-bit sign vector, optionally clears the counters, and streams the snapshot out as OUT_W-bit beats with a valid/ready handshake. It sits between the core array and the DMA/ACP write path. Over the previous single-core, fixed-1024-bit buffer it adds multi-core merging, tie-break mode, saturation, auto-clear and backpressure.

## Interface
Parameters:
- DIM, 1023: index of the top bit; vector width is DIM+1.
- CORENUM, 16: number of contributing cores.
- CNT_W, 30: width of each signed per-bit counter, two's complement.
- OUT_W, 1024: stream beat width; must divide DIM+1. NBEAT = (DIM+1)/OUT_W.
- TIE_MODE, 0: sign of a zero counter; 0 gives bit 0, 1 gives bit 1.
- AUTO_CLEAR, 1: 1 clears the counters at snapshot; 0 keeps accumulating.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- core_result  in  CORENUM*(DIM+1)  core c occupies [c*(DIM+1) +: DIM+1].
- store  in  CORENUM  per-core strobe; core c contributes this cycle.
- finish  in  1  single-cycle request to snapshot and stream.
- clear  in  1  zeroes the counters and the sticky flags.
- stream_d  out  OUT_W  current beat.
- stream_v  out  1  beat valid.
- stream_ready  in  1  consumer accepts the beat.
- stream_last  out  1  marks the final beat (NBEAT-1).
- busy  out  1  high in SNAP or SEND.
- drop  out  1  sticky: a `finish` was ignored.
- sat  out  1  sticky: some counter clamped.

## Operation
Counters:
- Each cycle, for each bit i: delta = sum over cores c with store[c]=1 of (+1 if core_result bit is 1, else -1). The range is ±CORENUM.
- The counter update is cnt + delta, clamped to [-2^(CNT_W-1), 2^(CNT_W-1)-1]. Clamping sets `sat`.
- Size the adder width for CORENUM so that no intermediate value wraps.
- `clear` has priority. The counters go to 0 and the stores in that cycle are discarded. `drop` and `sat` also go to 0.
- Sign rule: sign[i] = 1 if cnt>0, 0 if cnt<0, TIE_MODE if cnt==0.

State machine (IDLE, SNAP, SEND):
- IDLE: `finish` moves to SNAP.
- SNAP: one cycle. snap <= sign(cnt), beat index <= 0.
  - If AUTO_CLEAR=1, the counters load 0 + delta of this cycle, so SNAP-cycle stores belong to the next epoch.
  - Moves to SEND.
- SEND: stream_d = snap[beat*OUT_W +: OUT_W], stream_v=1, stream_last = (beat==NBEAT-1).
  - A handshake (stream_v & stream_ready) increments beat.
  - A handshake on the last beat returns to IDLE.

Rules while busy:
- Accumulation continues in every state.
- `finish` in SNAP or SEND is ignored and sets `drop`.
- `clear` in SEND does not abort the stream. The snapshot is independent of the counters.

## Timing
- Reset (rst=0, asynchronous) forces:
  - all counters, the snapshot and the beat index to 0;
  - state to IDLE;
  - stream_v, stream_last, busy, drop and sat to 0;
  - stream_d to 0.
- Reset mid-stream drops the transfer immediately.
- `finish` at cycle T:
  - the snapshot includes the stores of cycles ≤ T;
  - SNAP is at T+1;
  - stream_v rises at T+2;
  - busy rises at T+1.
- With stream_ready held high, the beats occupy T+2 … T+1+NBEAT, and busy falls at T+2+NBEAT.
- While stream_v=1 and stream_ready=0, stream_d, stream_v and stream_last hold stable.
- A `finish` arriving in the cycle after the last handshake is accepted (state is IDLE).
- `finish` and `clear` in the same IDLE cycle: the snapshot sees zero counters, giving all TIE_MODE bits.
- NBEAT=1: stream_last is high on the only beat.

## Test plan
Bench parameters: DIM=7, CORENUM=3, CNT_W=4, OUT_W=4, TIE_MODE=0, AUTO_CLEAR=1, unless noted.

1. Majority: cores 0xF0/0xCC/0xAA, store=3'b111 for one cycle, then finish, stream_ready=1. Required: snapshot 0xE8; beats 0x8 then 0xE, stream_last on the second; busy low 2+NBEAT=4 cycles after finish; counters 0 afterwards.
2. Tie: core0 stores 0xFF then 0x00, then finish. Required: 0x00 with TIE_MODE=0; 0xFF with TIE_MODE=1.
3. Backpressure: scenario 1 with stream_ready=0 for 5 cycles after stream_v rises. Required: stream_d=0x8 and stream_v=1 held stable; beat 0xE follows one cycle after ready rises.
4. Saturation: core0 stores 0xFF for 10 cycles. Required: counters clamp at +7 and sat=1. Then 7 stores of 0x00 and finish. Required: all counters 0, output 0x00, sat remains 1 until clear.
5. Overlap: finish during SEND. Required: drop=1, current stream unchanged. SNAP-cycle stores appear in the next epoch's output. clear sets drop=0 and sat=0.
6. Async reset: assert rst=0 mid-SEND, between clock edges. Required: stream_v, busy and stream_last are 0 immediately. After release, a new finish with no stores yields 0x00.
